// File: rtl/centroid_ctrl_pkg.sv
// Shared types and width helpers for the centroid scan controller and its
// frame-buffer port arbiter.
package centroid_ctrl_pkg;

   localparam int IMG_W_DEF = 640;
   localparam int IMG_H_DEF = 480;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SCAN,
      DRAIN,
      WAIT_RES,
      ABORT
   } state_e;

   // Owner of the read whose data comes back on the next cycle.
   typedef enum logic {
      TAG_DISP = 1'b0,
      TAG_SCAN = 1'b1
   } rtag_e;

   function automatic int x_w(input int img_w);
      return $clog2(img_w);
   endfunction

   function automatic int pix_w(input int img_w, input int img_h);
      return $clog2(img_w * img_h);
   endfunction

endpackage

// File: rtl/fb_port_arb.sv
// Frame-buffer read port arbiter: display has strict priority, scan fills idle
// cycles; a registered tag steers the 1-cycle-latency read data back.
module fb_port_arb
   import centroid_ctrl_pkg::*;
#(
   parameter int PIX_W = pix_w(IMG_W_DEF, IMG_H_DEF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             disp_req,
   input  logic [PIX_W-1:0] disp_addr,
   input  logic             scan_req,
   input  logic [PIX_W-1:0] scan_addr,
   input  logic [3:0]       mem_rdata,
   output logic             scan_gnt,
   output logic             mem_rd,
   output logic [PIX_W-1:0] mem_addr,
   output logic             disp_rvalid,
   output logic             dp_in_ready,
   output logic [3:0]       dp_pixel
);

   logic  rvld_q;
   rtag_e tag_q;

   assign scan_gnt = scan_req & ~disp_req;
   assign mem_rd   = disp_req | scan_gnt;
   assign mem_addr = disp_req ? disp_addr : scan_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         rvld_q <= 1'b0;
         tag_q  <= TAG_DISP;
      end else begin
         rvld_q <= mem_rd;
         tag_q  <= disp_req ? TAG_DISP : TAG_SCAN;
      end
   end

   assign disp_rvalid = rvld_q && (tag_q == TAG_DISP);
   assign dp_in_ready = rvld_q && (tag_q == TAG_SCAN);
   assign dp_pixel    = mem_rdata;

endmodule

// File: rtl/centroid_scan_ctrl.sv
// Sequences one centroid measurement: reset datapath, stream a frame through
// the shared read port, then capture the result or flag a timeout.
//
// state    | meaning
// IDLE     | waiting for start
// CLEAR    | dp_rst pulse, scan address cleared
// SCAN     | issue reads in cycles the display leaves free
// DRAIN    | final scan read returning
// WAIT_RES | wait for line_valid rising edge or timeout
// ABORT    | let an in-flight read land, then dp_rst pulse
module centroid_scan_ctrl
   import centroid_ctrl_pkg::*;
#(
   parameter  int IMG_W   = IMG_W_DEF,
   parameter  int IMG_H   = IMG_H_DEF,
   parameter  int TIMEOUT = 16,
   localparam int X_W     = x_w(IMG_W),
   localparam int PIX_W   = pix_w(IMG_W, IMG_H)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             disp_req,
   input  logic [PIX_W-1:0] disp_addr,
   output logic             disp_rvalid,
   output logic             mem_rd,
   output logic [PIX_W-1:0] mem_addr,
   input  logic [3:0]       mem_rdata,
   output logic             dp_rst,
   output logic             dp_in_ready,
   output logic [3:0]       dp_pixel,
   input  logic [X_W-1:0]   dp_centroid_x,
   input  logic             dp_line_valid,
   input  logic             dp_line_lost,
   output logic             busy,
   output logic             result_valid,
   output logic [X_W-1:0]   result_x,
   output logic             result_lost,
   output logic             timeout_err
);

   localparam int N_PIX = IMG_W * IMG_H;
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   state_e             state_q, state_d;
   logic [PIX_W-1:0]   scan_addr_q, scan_addr_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic               abt_wait_q, abt_wait_d;
   logic               lv_q;
   logic               res_vld_q, res_vld_d;
   logic [X_W-1:0]     res_x_q, res_x_d;
   logic               res_lost_q, res_lost_d;
   logic               tmo_q, tmo_d;
   logic               dp_rst_fsm;
   logic               scan_gnt;
   logic               lv_rise;

   fb_port_arb #(.PIX_W(PIX_W)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .disp_req    (disp_req),
      .disp_addr   (disp_addr),
      .scan_req    (state_q == SCAN),
      .scan_addr   (scan_addr_q),
      .mem_rdata   (mem_rdata),
      .scan_gnt    (scan_gnt),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .disp_rvalid (disp_rvalid),
      .dp_in_ready (dp_in_ready),
      .dp_pixel    (dp_pixel)
   );

   // The datapath holds line_valid until its next pixel, so only a rise counts.
   assign lv_rise = dp_line_valid & ~lv_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         scan_addr_q <= '0;
         tmr_q       <= '0;
         abt_wait_q  <= 1'b0;
         lv_q        <= 1'b0;
         res_vld_q   <= 1'b0;
         res_x_q     <= X_W'(IMG_W / 2);
         res_lost_q  <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         scan_addr_q <= scan_addr_d;
         tmr_q       <= tmr_d;
         abt_wait_q  <= abt_wait_d;
         lv_q        <= dp_line_valid;
         res_vld_q   <= res_vld_d;
         res_x_q     <= res_x_d;
         res_lost_q  <= res_lost_d;
         tmo_q       <= tmo_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      scan_addr_d = scan_addr_q;
      tmr_d       = tmr_q;
      abt_wait_d  = abt_wait_q;
      res_vld_d   = 1'b0;
      res_x_d     = res_x_q;
      res_lost_d  = res_lost_q;
      tmo_d       = tmo_q;
      dp_rst_fsm  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = CLEAR;
               tmo_d   = 1'b0;
            end
         end
         CLEAR: begin
            dp_rst_fsm  = 1'b1;
            scan_addr_d = '0;
            abt_wait_d  = 1'b0;
            state_d     = abort ? ABORT : SCAN;
         end
         SCAN: begin
            // Timeout window opens at DRAIN, the cycle of the last pixel.
            tmr_d = TMR_W'(TIMEOUT - 1);
            if (scan_gnt) scan_addr_d = scan_addr_q + PIX_W'(1);
            if (abort) begin
               state_d    = ABORT;
               abt_wait_d = scan_gnt;
            end else if (scan_gnt && scan_addr_q == PIX_W'(N_PIX - 1)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            tmr_d      = tmr_q - TMR_W'(1);
            abt_wait_d = 1'b0;
            state_d    = abort ? ABORT : WAIT_RES;
         end
         WAIT_RES: begin
            tmr_d      = tmr_q - TMR_W'(1);
            abt_wait_d = 1'b0;
            if (abort) begin
               state_d = ABORT;
            end else if (lv_rise) begin
               res_vld_d  = 1'b1;
               res_x_d    = dp_centroid_x;
               res_lost_d = dp_line_lost;
               state_d    = IDLE;
            end else if (tmr_q == '0) begin
               tmo_d   = 1'b1;
               state_d = IDLE;
            end
         end
         ABORT: begin
            if (abt_wait_q) begin
               abt_wait_d = 1'b0;
            end else begin
               dp_rst_fsm = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dp_rst       = rst | dp_rst_fsm;
   assign busy         = (state_q != IDLE);
   assign result_valid = res_vld_q;
   assign result_x     = res_x_q;
   assign result_lost  = res_lost_q;
   assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_centroid_scan_ctrl.sv
// Directed bench for centroid_scan_ctrl on an 8x4 frame with a behavioural
// frame buffer and centroid datapath.
module tb_centroid_scan_ctrl;

   localparam int IMG_W = 8;
   localparam int IMG_H = 4;
   localparam int N_PIX = IMG_W * IMG_H;
   localparam int X_W   = 3;
   localparam int PIX_W = 5;

   logic             clk = 1'b0;
   logic             rst, start, abort, disp_req;
   logic [PIX_W-1:0] disp_addr;
   logic             disp_rvalid, mem_rd, dp_rst, dp_in_ready;
   logic [PIX_W-1:0] mem_addr;
   logic [3:0]       mem_rdata, dp_pixel;
   logic [X_W-1:0]   dp_centroid_x, result_x;
   logic             dp_line_valid, dp_line_lost;
   logic             busy, result_valid, result_lost, timeout_err;

   int n_chk  = 0;
   int n_fail = 0;
   int seed   = 0;
   bit stuck  = 1'b0;
   bit prev_req = 1'b0;
   int dm_cnt, dm_sum;

   always #5 clk = ~clk;

   centroid_scan_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .dp_rst(dp_rst), .dp_in_ready(dp_in_ready), .dp_pixel(dp_pixel),
      .dp_centroid_x(dp_centroid_x), .dp_line_valid(dp_line_valid),
      .dp_line_lost(dp_line_lost), .busy(busy), .result_valid(result_valid),
      .result_x(result_x), .result_lost(result_lost), .timeout_err(timeout_err)
   );

   function automatic logic [3:0] pix(input int a, input int s);
      int v;
      v = a * a + s * 3 + (a >> 2);
      return v[3:0];
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Frame buffer: fixed 1-cycle read latency.
   always @(posedge clk) mem_rdata <= pix(int'(mem_addr), seed);

   // Datapath: result registered one cycle after the last pixel, held until next pixel.
   always @(posedge clk) begin
      if (dp_rst) begin
         dm_cnt <= 0; dm_sum <= 0;
         dp_line_valid <= 1'b0; dp_centroid_x <= '0; dp_line_lost <= 1'b0;
      end else if (dp_in_ready) begin
         dp_line_valid <= 1'b0;
         if (dm_cnt == N_PIX - 1) begin
            dm_cnt <= 0; dm_sum <= 0;
            dp_line_valid <= !stuck;
            dp_centroid_x <= 3'((dm_sum + int'(dp_pixel)) & 7);
            dp_line_lost  <= 1'(((dm_sum + int'(dp_pixel)) >> 3) & 1);
         end else begin
            dm_cnt <= dm_cnt + 1;
            dm_sum <= dm_sum + int'(dp_pixel);
         end
      end
   end

   // Display path: grant in the request cycle, data valid one cycle later.
   always @(negedge clk) begin
      if (prev_req || disp_rvalid) begin
         chk("disp_rvalid", disp_rvalid, prev_req);
         if (disp_rvalid) chk("rtn_exclusive", dp_in_ready, 0);
      end
      if (disp_req) begin
         chk("grant_rd", mem_rd, 1);
         chk("grant_addr", mem_addr, disp_addr);
      end
      prev_req = disp_req;
   end

   typedef struct {
      int disp_per;    // display request every Nth cycle, 0 = none
      int abort_r;     // cycle (relative to start) to pulse abort, -1 = none
      bit stuck;       // datapath never raises line_valid
      bit start_mid;   // extra start pulse during SCAN
      int exp_pulses;
      int exp_last;    // cycle of last dp_in_ready, -1 = none
      int exp_idle;    // first cycle back in IDLE
      int exp_rv;
      int exp_tmo;
      int exp_drst;
   } vec_t;

   vec_t vecs[8];

   task automatic check_reset_vals(input string tag);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " result_valid"}, result_valid, 0);
      chk({tag, " result_lost"}, result_lost, 0);
      chk({tag, " timeout_err"}, timeout_err, 0);
      chk({tag, " mem_rd"}, mem_rd, 0);
      chk({tag, " disp_rvalid"}, disp_rvalid, 0);
      chk({tag, " dp_in_ready"}, dp_in_ready, 0);
      chk({tag, " result_x"}, result_x, IMG_W / 2);
      chk({tag, " dp_rst"}, dp_rst, 1);
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int pulses, drst, rvc, last, idle_r, sum, ex, el;
      bit done;
      string nm;
      v = vecs[idx];
      nm = $sformatf("v%0d", idx);
      seed = idx + 1;
      stuck = v.stuck;
      sum = 0;
      for (int a = 0; a < N_PIX; a++) sum += int'(pix(a, seed));
      ex = sum & 7;
      el = (sum >> 3) & 1;
      pulses = 0; drst = 0; rvc = 0; last = -1; idle_r = -1; done = 1'b0;
      for (int r = 0; r < 120 && !done; r++) begin
         start     = (r == 0) || (v.start_mid && r == 10);
         abort     = (r == v.abort_r);
         disp_req  = (v.disp_per != 0) && ((r % v.disp_per) == v.disp_per - 1);
         disp_addr = PIX_W'(r * 7);
         @(negedge clk);
         if (dp_in_ready) begin
            chk({nm, " pixel"}, dp_pixel, pix(pulses, seed));
            pulses++;
            last = r;
         end
         if (dp_rst) drst++;
         if (result_valid) begin
            rvc++;
            chk({nm, " result_x"}, result_x, ex);
            chk({nm, " result_lost"}, result_lost, el);
         end
         if (r == 1) chk({nm, " tmo_cleared"}, timeout_err, 0);
         if (r == 2 && v.disp_per == 0 && v.abort_r != 1) begin
            chk({nm, " first_rd"}, mem_rd, 1);
            chk({nm, " first_addr"}, mem_addr, 0);
         end
         if (r > 0 && !busy) begin
            idle_r = r;
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; abort = 1'b0; disp_req = 1'b0;
      chk({nm, " idle_cycle"}, idle_r, v.exp_idle);
      chk({nm, " pulses"}, pulses, v.exp_pulses);
      chk({nm, " last_pixel"}, last, v.exp_last);
      chk({nm, " result_valid_cnt"}, rvc, v.exp_rv);
      chk({nm, " timeout_err"}, timeout_err, v.exp_tmo);
      chk({nm, " dp_rst_cycles"}, drst, v.exp_drst);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      //          per abort stk mid puls last idle rv tmo drst
      vecs[0] = '{0, -1, 1'b0, 1'b0, 32, 34, 36, 1, 0, 1};
      vecs[1] = '{3, -1, 1'b0, 1'b0, 32, 50, 52, 1, 0, 1};
      vecs[2] = '{0, 19, 1'b0, 1'b0, 18, 20, 22, 0, 0, 2};
      vecs[3] = '{0, -1, 1'b0, 1'b0, 32, 34, 36, 1, 0, 1};
      vecs[4] = '{0, -1, 1'b1, 1'b0, 32, 34, 50, 0, 1, 1};
      vecs[5] = '{0, -1, 1'b0, 1'b1, 32, 34, 36, 1, 0, 1};
      vecs[6] = '{0, 35, 1'b0, 1'b0, 32, 34, 37, 0, 0, 2};
      vecs[7] = '{0,  1, 1'b0, 1'b0,  0, -1,  3, 0, 0, 2};

      rst = 1'b1; start = 1'b0; abort = 1'b0; disp_req = 1'b0; disp_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset dp_rst", dp_rst, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) run_vec(i);

      // start and abort together in IDLE: no scan begins
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("start_abort busy", busy, 0);
      chk("start_abort dp_rst", dp_rst, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("start_abort busy2", busy, 0);
      @(posedge clk); #1;

      // synchronous reset in the middle of SCAN
      seed = 9; stuck = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      @(negedge clk);
      chk("midscan busy_before", busy, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midscan dp_rst_comb", dp_rst, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check_reset_vals("midscan");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("recover busy", busy, 0);
      chk("recover dp_rst", dp_rst, 0);
      chk("recover dp_in_ready", dp_in_ready, 0);
      @(posedge clk); #1;

      run_vec(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
